// File: rtl/seg7_display.sv
// seg7_display: CPU-written, time-multiplexed 8-digit seven-segment driver.
// Writes are edge-detected on the I/O strobe (one commit per assertion) and
// land in digit, blank-mask and dp-mask registers. A scan counter steps
// through the 8 common-anode digits; anodes and segments are active-low.
//
// Ports:
//   wb_clk_i  system clock, rising edge
//   wb_rst_i  asynchronous active-high reset
//   IOW_N     active-low I/O write strobe
//   CS_N      active-low chip select
//   addr      register select: 0 DIG_LO, 1 DIG_HI, 2 CTRL, 3 ignored
//   wb_dat_i  write data
//   an        digit anodes, active-low, an[i] selects digit i
//   seg       segments, active-low, {dp,g,f,e,d,c,b,a}
module seg7_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        IOW_N,
  input  logic        CS_N,
  input  logic [1:0]  addr,
  input  logic [15:0] wb_dat_i,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NDIG    = 8;
  localparam int unsigned NIB_W   = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic                   wr_d;
  logic [NDIG*NIB_W-1:0]  digits;
  logic [NDIG-1:0]        blank;
  logic [NDIG-1:0]        dp;

  logic                   wr_c;
  logic                   wr_stb_c;
  logic [NIB_W-1:0]       cur_digit_c;
  logic [6:0]             dec_c;

  assign wr_c        = ~CS_N & ~IOW_N;
  assign wr_stb_c    = wr_c & ~wr_d;
  assign cur_digit_c = digits[{idx, 2'b00} +: NIB_W];

  // Strobe edge detect; wr_d resets high so a strobe held through reset is ignored.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wr_d <= 1'b1;
    else          wr_d <= wr_c;
  end

  // Register file, written once per strobe assertion.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      digits <= '0;
      blank  <= 8'hFF;
      dp     <= 8'h00;
    end else if (wr_stb_c) begin
      case (addr)
        2'd0:    digits[15:0]  <= wb_dat_i;
        2'd1:    digits[31:16] <= wb_dat_i;
        2'd2: begin
          blank <= wb_dat_i[7:0];
          dp    <= wb_dat_i[15:8];
        end
        default: ;
      endcase
    end
  end

  // Scan timing: each digit held for SCAN_DIV cycles.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    dec_c = 7'h7F;
    case (cur_digit_c)
      4'h0: dec_c = 7'h40;
      4'h1: dec_c = 7'h79;
      4'h2: dec_c = 7'h24;
      4'h3: dec_c = 7'h30;
      4'h4: dec_c = 7'h19;
      4'h5: dec_c = 7'h12;
      4'h6: dec_c = 7'h02;
      4'h7: dec_c = 7'h78;
      4'h8: dec_c = 7'h00;
      4'h9: dec_c = 7'h10;
      4'hA: dec_c = 7'h08;
      4'hB: dec_c = 7'h03;
      4'hC: dec_c = 7'h46;
      4'hD: dec_c = 7'h21;
      4'hE: dec_c = 7'h06;
      4'hF: dec_c = 7'h0E;
      default: dec_c = 7'h7F;
    endcase
  end

  // Registered drive of the currently selected digit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else if (blank[idx]) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= {~dp[idx], dec_c};
    end
  end

endmodule

// File: tb/tb_seg7_display.sv
// Directed bench for seg7_display with SCAN_DIV=4.
module tb_seg7_display;

  localparam int SCAN = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        IOW_N    = 1'b1;
  logic        CS_N     = 1'b1;
  logic [1:0]  addr     = 2'd0;
  logic [15:0] wb_dat_i = 16'h0000;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  // Expected register contents, updated as the bench writes.
  logic [31:0] m_dig   = 32'h0;
  logic [7:0]  m_blank = 8'hFF;
  logic [7:0]  m_dp    = 8'h00;

  seg7_display #(.SCAN_DIV(SCAN)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .IOW_N    (IOW_N),
    .CS_N     (CS_N),
    .addr     (addr),
    .wb_dat_i (wb_dat_i),
    .an       (an),
    .seg      (seg)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Rising edges since the last reset release.
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic [2:0]  dig;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  // Expected {an, seg} for the current sample point.
  function automatic logic [15:0] exp_out();
    logic [2:0] i;
    if (ecnt == 0) return 16'hFFFF;
    i = 3'(((ecnt - 1) / SCAN) % 8);
    if (m_blank[i]) return 16'hFFFF;
    return {~(8'b1 << i), ~m_dp[i], dec(m_dig[{i, 2'b00} +: 4])};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    logic [15:0] e;
    e = exp_out();
    chk({name, ".an"}, an, e[15:8]);
    chk({name, ".seg"}, seg, e[7:0]);
  endtask

  task automatic follow(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge wb_clk_i);
      chk_model(name);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge wb_clk_i);
    CS_N = 1'b0; IOW_N = 1'b0; addr = a; wb_dat_i = d;
    @(negedge wb_clk_i);
    CS_N = 1'b1; IOW_N = 1'b1;
    case (a)
      2'd0: m_dig[15:0]  = d;
      2'd1: m_dig[31:16] = d;
      2'd2: begin m_blank = d[7:0]; m_dp = d[15:8]; end
      default: ;
    endcase
  endtask

  // Advance to a sample point where digit d is being displayed.
  task automatic wait_slot(input logic [2:0] d);
    bit hit = 1'b0;
    for (int k = 0; k < 10 * SCAN; k++) begin
      @(negedge wb_clk_i);
      if (ecnt != 0 && 3'(((ecnt - 1) / SCAN) % 8) == d) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_slot: digit %0d never selected", d);
    end
  endtask

  vec_t vecs [10];
  logic [7:0] walk_seg [8];

  initial begin
    vecs[0] = '{2'd0, 16'h3210, 3'd0, 8'hFF, 8'hFF};
    vecs[1] = '{2'd1, 16'h7654, 3'd5, 8'hFF, 8'hFF};
    vecs[2] = '{2'd2, 16'h0000, 3'd0, 8'hFE, 8'hC0};
    vecs[3] = '{2'd0, 16'h3210, 3'd2, 8'hFB, 8'hA4};
    vecs[4] = '{2'd2, 16'h8001, 3'd0, 8'hFF, 8'hFF};
    vecs[5] = '{2'd2, 16'h8001, 3'd7, 8'h7F, 8'h78};
    vecs[6] = '{2'd2, 16'h0200, 3'd1, 8'hFD, 8'h79};
    vecs[7] = '{2'd1, 16'hFEDC, 3'd4, 8'hEF, 8'hC6};
    vecs[8] = '{2'd1, 16'hFEDC, 3'd7, 8'h7F, 8'h8E};
    vecs[9] = '{2'd2, 16'h0000, 3'd5, 8'hDF, 8'hA1};
    walk_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    // Reset state, then idle: display stays dark.
    #12;
    chk("reset.an", an, 8'hFF);
    chk("reset.seg", seg, 8'hFF);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int k = 0; k < 8 * SCAN; k++) begin
      @(negedge wb_clk_i);
      chk("idle.an", an, 8'hFF);
      chk("idle.seg", seg, 8'hFF);
    end

    // Table: write, then observe a chosen digit slot.
    for (int v = 0; v < 10; v++) begin
      wr(vecs[v].addr, vecs[v].data);
      wait_slot(vecs[v].dig);
      chk($sformatf("vec%0d.an", v), an, vecs[v].an);
      chk($sformatf("vec%0d.seg", v), seg, vecs[v].seg);
    end

    // Plain 0..7 walk.
    wr(2'd1, 16'h7654);
    wr(2'd2, 16'h0000);
    for (int d = 0; d < 8; d++) begin
      wait_slot(3'(d));
      chk($sformatf("walk%0d.an", d), an, ~(8'b1 << d));
      chk($sformatf("walk%0d.seg", d), seg, walk_seg[d]);
    end
    follow("walk", 8 * SCAN + 4);

    // Long strobe: only the first data word commits.
    @(negedge wb_clk_i);
    CS_N = 1'b0; IOW_N = 1'b0; addr = 2'd0; wb_dat_i = 16'hAAAA;
    repeat (5) @(negedge wb_clk_i);
    wb_dat_i = 16'hBBBB;
    repeat (5) @(negedge wb_clk_i);
    CS_N = 1'b1; IOW_N = 1'b1;
    m_dig[15:0] = 16'hAAAA;
    wait_slot(3'd0);
    chk("hold.d0.an", an, 8'hFE);
    chk("hold.d0.seg", seg, 8'h88);
    wait_slot(3'd1);
    chk("hold.d1.seg", seg, 8'h88);

    // Ignored writes: addr 3, and IOW_N without chip select.
    wr(2'd3, 16'h0000);
    @(negedge wb_clk_i);
    CS_N = 1'b1; IOW_N = 1'b0; addr = 2'd0; wb_dat_i = 16'h0000;
    @(negedge wb_clk_i);
    IOW_N = 1'b1;
    @(negedge wb_clk_i);
    CS_N = 1'b1; IOW_N = 1'b0; addr = 2'd2; wb_dat_i = 16'h00FF;
    @(negedge wb_clk_i);
    IOW_N = 1'b1;
    follow("nowrite", 8 * SCAN + 4);

    // Asynchronous reset while digit 3 is lit.
    wait_slot(3'd3);
    chk("pre_rst.an", an, 8'hF7);
    chk("pre_rst.seg", seg, 8'h88);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("async_rst.an", an, 8'hFF);
    chk("async_rst.seg", seg, 8'hFF);
    m_dig = 32'h0; m_blank = 8'hFF; m_dp = 8'h00;
    // Strobe held across reset release must not write CTRL.
    CS_N = 1'b0; IOW_N = 1'b0; addr = 2'd2; wb_dat_i = 16'h0000;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    CS_N = 1'b1; IOW_N = 1'b1;
    follow("post_rst_dark", 8 * SCAN);

    // After CTRL write all digits show 0 with the scan restarted from 0.
    wr(2'd2, 16'h0000);
    follow("post_rst_walk", 8 * SCAN + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
